// File: rtl/hp_exec_ctrl.sv
// hp_exec_ctrl -- execute stage of the hp_core RV32I single-issue datapath.
//
// Decodes opcode/funct3/funct7 into datapath controls, picks the ALU
// operation and second operand, computes the ALU result, and registers
// everything once to form the EX output register.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        instruction fields and operands valid this cycle
//   inst            instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
//   rs1_data        operand 1
//   rs2_data        register operand 2
//   imm             sign-extended immediate
//   out_valid       registered outputs valid (in_valid delayed one cycle)
//   alu_out         registered ALU result / memory address
//   alu_zero        registered alu_out == 0
//   store_data      registered rs2_data (memory write data)
//   alu_src, reg_write, mem_read, mem_write, mem_to_reg   registered controls
//   illegal         registered unsupported opcode / function code flag
//
// Handshake: in_valid qualifies the inputs of the current cycle and
// out_valid qualifies the registered outputs one cycle later. There is no
// ready; the block accepts one instruction every cycle.
//
// Optional feature: define HP_EXEC_MUL_EN to add RV32M MUL (funct7 0000001,
// funct3 000) to the R-type decode.
module hp_exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] inst,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        out_valid,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  output logic [31:0] store_data,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        illegal
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register indices and immediate fields are handled elsewhere in the core.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  // Plain funct3 mapping; 101 defaults to the logical shift.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic    alu_src_d, reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d;
  logic    illegal_d, bad_opcode;
  alu_op_e alu_op;

  always_comb begin
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    illegal_d    = 1'b0;
    bad_opcode   = 1'b0;
    alu_op       = ALU_ADD;
    case (opcode)
      OPC_R: begin
        reg_write_d = 1'b1;
        alu_op      = base_op(funct3);
        case (funct7)
          F7_BASE: ;
          F7_ALT: begin
            if (funct3 == 3'b000)      alu_op = ALU_SUB;
            else if (funct3 == 3'b101) alu_op = ALU_SRA;
            else                       illegal_d = 1'b1;
          end
          F7_MULDIV: begin
`ifdef HP_EXEC_MUL_EN
            if (funct3 == 3'b000) alu_op = ALU_MUL;
            else                  illegal_d = 1'b1;
`else
            illegal_d = 1'b1;
`endif
          end
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_I: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op      = base_op(funct3);
        // funct7 only exists as an encoding field for the shift-immediates.
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal_d = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)        alu_op = ALU_SRA;
          else if (funct7 != F7_BASE)  illegal_d = 1'b1;
        end
      end
      OPC_LOAD: begin
        alu_src_d    = 1'b1;
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      OPC_STORE: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      default: begin
        illegal_d  = 1'b1;
        bad_opcode = 1'b1;
      end
    endcase
    if (illegal_d) reg_write_d = 1'b0;
  end

  logic [31:0] op2, alu_res;
  assign op2 = alu_src_d ? imm : rs2_data;

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_res = rs1_data + op2;
      ALU_SUB:  alu_res = rs1_data - op2;
      ALU_SLL:  alu_res = rs1_data << op2[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(rs1_data) < $signed(op2)};
      ALU_SLTU: alu_res = {31'd0, rs1_data < op2};
      ALU_XOR:  alu_res = rs1_data ^ op2;
      ALU_SRL:  alu_res = rs1_data >> op2[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_data) >>> op2[4:0]);
      ALU_OR:   alu_res = rs1_data | op2;
      ALU_AND:  alu_res = rs1_data & op2;
`ifdef HP_EXEC_MUL_EN
      ALU_MUL:  alu_res = rs1_data * op2;
`endif
      default:  alu_res = 32'd0;
    endcase
    if (bad_opcode) alu_res = 32'd0;
  end

  // EX output register. Write enables are gated by in_valid; everything
  // else captures unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_out    <= 32'd0;
      alu_zero   <= 1'b0;
      store_data <= 32'd0;
      alu_src    <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      alu_out    <= alu_res;
      alu_zero   <= (alu_res == 32'd0);
      store_data <= rs2_data;
      alu_src    <= alu_src_d;
      reg_write  <= reg_write_d & in_valid;
      mem_read   <= mem_read_d & in_valid;
      mem_write  <= mem_write_d & in_valid;
      mem_to_reg <= mem_to_reg_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_hp_exec_ctrl.sv
// Directed testbench for hp_exec_ctrl. Inputs are driven 1 time unit after
// the rising edge and outputs are checked 1 time unit after the next one.
module tb_hp_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst, rs1_data, rs2_data, imm;
  logic        out_valid, alu_zero, alu_src, reg_write, mem_read, mem_write;
  logic        mem_to_reg, illegal;
  logic [31:0] alu_out, store_data;

  int total = 0;
  int bad   = 0;

  hp_exec_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .out_valid(out_valid), .alu_out(alu_out), .alu_zero(alu_zero),
    .store_data(store_data), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .illegal(illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic r, input logic v, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    rst = r; in_valid = v; inst = i; rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // checking
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ctrl order: {out_valid, alu_src, reg_write, mem_read, mem_write,
  //              mem_to_reg, illegal, alu_zero}
  function automatic logic [7:0] ctrl_now();
    return {out_valid, alu_src, reg_write, mem_read, mem_write,
            mem_to_reg, illegal, alu_zero};
  endfunction

  task automatic expect_all(input string tag, input logic [7:0] ctrl,
                            input logic [31:0] alu, input logic [31:0] sd);
    chk({tag, ".ctrl"}, {24'd0, ctrl_now()}, {24'd0, ctrl});
    chk({tag, ".alu"}, alu_out, alu);
    chk({tag, ".sd"}, store_data, sd);
  endtask

  logic [7:0]  mul_ctrl;
  logic [31:0] mul_alu;

  initial begin
    drive(1'b1, 1'b1, 32'h40208033, 32'd5, 32'd7, 32'd0);

    // reset held two cycles with a valid instruction presented
    tick();
    expect_all("reset1", 8'b0000_0000, 32'd0, 32'd0);
    tick();
    expect_all("reset2", 8'b0000_0000, 32'd0, 32'd0);

    // SUB 5 - 7 right after release
    drive(1'b0, 1'b1, 32'h40208033, 32'd5, 32'd7, 32'd0);
    tick();
    expect_all("sub", 8'b1010_0000, 32'hFFFF_FFFE, 32'd7);

    // SRAI / SRLI by 4
    drive(1'b0, 1'b1, 32'h40405093, 32'h8000_0000, 32'd0, 32'h404);
    tick();
    expect_all("srai", 8'b1110_0000, 32'hF800_0000, 32'd0);
    drive(1'b0, 1'b1, 32'h00405093, 32'h8000_0000, 32'd0, 32'h404);
    tick();
    expect_all("srli", 8'b1110_0000, 32'h0800_0000, 32'd0);

    // load / store address generation
    drive(1'b0, 1'b1, 32'h0040A083, 32'h100, 32'h55, 32'd4);
    tick();
    expect_all("load", 8'b1111_0100, 32'h104, 32'h55);
    drive(1'b0, 1'b1, 32'h0020A223, 32'h100, 32'hDEAD_BEEF, 32'd4);
    tick();
    expect_all("store", 8'b1100_1000, 32'h104, 32'hDEAD_BEEF);

    // signed vs unsigned compare, wrapping add
    drive(1'b0, 1'b1, 32'h0020A033, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    expect_all("slt", 8'b1010_0000, 32'd1, 32'd1);
    drive(1'b0, 1'b1, 32'h0020B033, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    expect_all("sltu", 8'b1010_0001, 32'd0, 32'd1);
    drive(1'b0, 1'b1, 32'h00208033, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    expect_all("add_wrap", 8'b1010_0001, 32'd0, 32'd1);

    // logic ops and register shift (shamt = rs2[4:0] = 3)
    drive(1'b0, 1'b1, 32'h0020C033, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    tick();
    expect_all("xor", 8'b1010_0000, 32'h0FF0_0FF0, 32'hFF00_FF00);
    drive(1'b0, 1'b1, 32'h0020E033, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    tick();
    expect_all("or", 8'b1010_0000, 32'hFFF0_FFF0, 32'hFF00_FF00);
    drive(1'b0, 1'b1, 32'h0020F033, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    tick();
    expect_all("and", 8'b1010_0000, 32'hF000_F000, 32'hFF00_FF00);
    drive(1'b0, 1'b1, 32'h00209033, 32'd1, 32'h23, 32'd0);
    tick();
    expect_all("sll", 8'b1010_0000, 32'd8, 32'h23);

    // ADDI -1: funct7 field is immediate bits, not checked
    drive(1'b0, 1'b1, 32'hFFF0_8093, 32'd5, 32'd0, 32'hFFFF_FFFF);
    tick();
    expect_all("addi_neg", 8'b1110_0000, 32'd4, 32'd0);

    // illegal opcode
    drive(1'b0, 1'b1, 32'h0000_007F, 32'd9, 32'd3, 32'd1);
    tick();
    expect_all("bad_opc", 8'b1000_0011, 32'd0, 32'd3);

    // R-type funct7 = 0100000 with funct3 001 is illegal
    drive(1'b0, 1'b1, 32'h40209033, 32'd1, 32'd2, 32'd0);
    tick();
    chk("bad_r_f7", {29'd0, out_valid, reg_write, illegal}, 32'b101);

    // SLLI with funct7 = 0100000 is illegal
    drive(1'b0, 1'b1, 32'h40409093, 32'd1, 32'd0, 32'h404);
    tick();
    chk("bad_slli_f7", {29'd0, out_valid, reg_write, illegal}, 32'b101);

    // funct7 = 0000001: MUL when enabled, illegal otherwise
`ifdef HP_EXEC_MUL_EN
    mul_ctrl = 8'b1010_0000;
    mul_alu  = 32'd42;
`else
    mul_ctrl = 8'b1000_0010;
    mul_alu  = 32'd0;
`endif
    drive(1'b0, 1'b1, 32'h02208033, 32'd6, 32'd7, 32'd0);
    tick();
    chk("mul.ctrl", {25'd0, ctrl_now() >> 1}, {25'd0, mul_ctrl >> 1});
    if (mul_ctrl[6:5] == 2'b01) chk("mul.alu", alu_out, mul_alu);

    // in_valid low: write enables drop, datapath still captures
    drive(1'b0, 1'b0, 32'h0040A083, 32'h100, 32'd0, 32'd4);
    tick();
    expect_all("no_valid", 8'b0100_0100, 32'h104, 32'd0);

    // reset mid-stream drops the instruction presented with it
    drive(1'b0, 1'b1, 32'h00208033, 32'd1, 32'd2, 32'd0);
    tick();
    expect_all("pre_rst", 8'b1010_0000, 32'd3, 32'd2);
    drive(1'b1, 1'b1, 32'h00208033, 32'd10, 32'd20, 32'd0);
    tick();
    expect_all("mid_rst", 8'b0000_0000, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'h00208033, 32'd10, 32'd20, 32'd0);
    tick();
    expect_all("post_rst", 8'b1010_0000, 32'd30, 32'd20);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
